// File: rtl/spi_adc_responder.sv
// spi_adc_responder
// SPI mode-0 slave that emulates the ADC end of the link. Each frame it shifts
// out LEAD_ZEROS zero bits followed by a DATA_W-bit sample, MSB first, and it
// captures the FRAME_LEN bits that the master sends on MOSI. SCK, CS and MOSI
// are oversampled by clk through SYNC_STAGES flops plus one edge-detect register.
module spi_adc_responder #(
  parameter  int DATA_W      = 12,
  parameter  int LEAD_ZEROS  = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int FRAME_LEN   = DATA_W + LEAD_ZEROS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 SCK,
  input  logic                 CS,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic                 miso_oe,
  input  logic [DATA_W-1:0]    sample_in,
  input  logic                 sample_valid,
  output logic                 busy,
  output logic [FRAME_LEN-1:0] rx_data,
  output logic                 frame_done,
  output logic                 frame_err
);

  // The bit counter needs one spare bit so that long frames stay distinguishable
  // from exact ones; it saturates at its all-ones value.
  localparam int                CNT_W     = $clog2(FRAME_LEN) + 1;
  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  // Pin synchronizers: bit 0 is the first stage, the MSB is the settled value.
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_q, cs_q;
  // warm fills with ones once every synchronizer stage holds a real pin sample.
  logic [SYNC_STAGES-1:0] warm;
  logic                   cs_armed;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;

  logic [DATA_W-1:0]    sample_hold;
  logic [FRAME_LEN-1:0] shift_reg;
  logic [FRAME_LEN-1:0] rx_shift;
  logic [CNT_W-1:0]     bit_cnt;

  logic load_frame;
  logic shift_en;

  // Synchronize the SPI pins and keep one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    // NOTE: every clocked register uses <= so all flops update from the values
    // of the previous cycle, independent of statement order.
    if (reset) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      warm      <= '0;
      cs_armed  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sck_q     <= sck_s;
      cs_q      <= cs_s;
      warm      <= {warm[SYNC_STAGES-2:0], 1'b1};
      // CS must be seen high on a real sample before a falling edge counts, so
      // a CS already low when reset drops cannot start a frame.
      cs_armed  <= cs_armed | (warm[SYNC_STAGES-1] & cs_s);
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_q;
  assign sck_fall = ~sck_s &  sck_q;
  assign cs_rise  =  cs_s  & ~cs_q;
  assign cs_fall  = ~cs_s  &  cs_q & cs_armed;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and frame-level outputs.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can leave
    // one unassigned, which would otherwise infer a latch.
    state_next = state;
    load_frame = 1'b0;
    shift_en   = 1'b0;
    busy       = 1'b0;
    miso_oe    = 1'b0;
    MISO       = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          load_frame = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        miso_oe = 1'b1;
        MISO    = shift_reg[FRAME_LEN-1];
        // A CS release wins over any SCK edge detected in the same cycle.
        if (cs_rise) begin
          state_next = DONE;
        end else begin
          shift_en = 1'b1;
        end
      end
      DONE: begin
        if (bit_cnt == FRAME_CNT) begin
          frame_done = 1'b1;
        end else begin
          frame_err = 1'b1;
        end
        // A new CS fall already seen here starts the next frame immediately.
        if (cs_fall) begin
          load_frame = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Sample hold register; loads in any state and only feeds the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_hold <= '0;
    end else if (sample_valid) begin
      sample_hold <= sample_in;
    end
  end

  // Frame datapath: MISO shift register, MOSI capture and bit counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
    end else if (load_frame) begin
      // A sample strobed in the load cycle bypasses the hold register.
      shift_reg <= {{LEAD_ZEROS{1'b0}}, (sample_valid ? sample_in : sample_hold)};
      rx_shift  <= '0;
      bit_cnt   <= '0;
    end else if (shift_en) begin
      if (sck_rise) begin
        rx_shift <= {rx_shift[FRAME_LEN-2:0], mosi_s};
        if (bit_cnt != '1) begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
      if (sck_fall) begin
        shift_reg <= {shift_reg[FRAME_LEN-2:0], 1'b0};
      end
    end
  end

  // Publish the captured MOSI word only when the frame had the exact length.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data <= '0;
    end else if (frame_done) begin
      rx_data <= rx_shift;
    end
  end

endmodule

// File: doc/spi_adc_responder.md
Name: spi_adc_responder

Overview:
- SPI slave that plays the ADC end of the link driven by SPI_state_machine.
- It drives MISO with 4 leading zeros followed by a 12-bit sample, MSB first, in SPI mode 0.
- It also captures the 16 bits the master sends on MOSI.
- Used as an on-chip ADC emulator for loopback bring-up and for regression benches of the SPI master and LED_TEST path.

Parameters:
- DATA_W, 12, sample width in bits.
- LEAD_ZEROS, 4, zero bits sent before the sample. Frame length FRAME_LEN = DATA_W + LEAD_ZEROS = 16.
- SYNC_STAGES, 2, flip-flop stages on each of SCK, CS and MOSI (minimum 2).

Ports:
- clk, input, 1, system clock; oversamples the SPI pins.
- reset, input, 1, synchronous active-high reset.
- SCK, input, 1, SPI clock from the master; CPOL=0.
- CS, input, 1, chip select, active low.
- MOSI, input, 1, master-to-slave data.
- MISO, output, 1, slave-to-master data.
- miso_oe, output, 1, high while a frame is active (CS low).
- sample_in, input, DATA_W, next sample value.
- sample_valid, input, 1, one-cycle strobe that loads sample_in into the hold register.
- busy, output, 1, high while in the SHIFT state.
- rx_data, output, FRAME_LEN, last complete MOSI frame.
- frame_done, output, 1, one-cycle pulse when a frame ends cleanly.
- frame_err, output, 1, one-cycle pulse when a frame ends with a bad bit count.

Behaviour:
- Reset (synchronous, active high), all registers cleared:
  - MISO=0, miso_oe=0, busy=0, rx_data=0, frame_done=0, frame_err=0.
  - sample_hold=0, bit_cnt=0, state=IDLE.
  - Synchronizers preset to CS=1, SCK=0, MOSI=0. A CS already held low when reset drops does not start a frame; a real falling edge is required.
- Pin input path:
  - SCK, CS and MOSI each pass through SYNC_STAGES flip-flops, then one edge-detect register.
  - Pin-to-detected-edge latency is SYNC_STAGES+1 clk cycles.
  - Requirement on the master: SCK high and low phases are each at least SYNC_STAGES+2 clk cycles.
- Sample hold:
  - sample_valid=1 loads sample_in into sample_hold in any state.
  - During SHIFT the shift register is unaffected; the new value is used for the next frame.
- State machine, IDLE -> SHIFT -> DONE -> IDLE:
  - IDLE: MISO=0, miso_oe=0.
    - On a detected CS falling edge: load shift_reg = {LEAD_ZEROS zeros, sample_hold}, clear bit_cnt, go to SHIFT.
    - If sample_valid is high in that same cycle, sample_in bypasses the hold register and goes into the frame.
  - SHIFT: busy=1, miso_oe=1, MISO = shift_reg MSB.
    - Detected SCK rising edge: shift MOSI into rx_shift (MSB first); bit_cnt increments and saturates at 31.
    - Detected SCK falling edge: shift_reg shifts left by one with 0 fill.
    - The first bit is therefore on MISO before the first SCK rise.
    - Detected CS rising edge: go to DONE. This takes priority over an SCK edge detected in the same cycle; that SCK edge is ignored.
  - DONE, one cycle:
    - If bit_cnt == FRAME_LEN: rx_data <= rx_shift and frame_done=1.
    - Otherwise: frame_err=1 and rx_data is unchanged. This covers short frames (CS released early) and long frames (more than 16 SCK rises).
    - Then go to IDLE, with MISO=0 and miso_oe=0.
    - A CS falling edge detected during DONE is honoured: the block goes directly to SHIFT with a fresh load.
- SCK edges while in IDLE are ignored.
- Reset asserted mid-frame aborts the frame: no frame_done or frame_err pulse, and outputs take their reset values in the next cycle.

Test Plan:
- Basic frame: sample_valid with sample_in=12'hA5C, then a 16-clock mode-0 frame with half-period 8 clk and MOSI=16'h3C96 -> master captures 16'h0A5C; rx_data=16'h3C96; exactly one frame_done pulse; frame_err never high.
- Back-to-back frames: samples 12'h001 then 12'hFFF loaded between frames, CS high gap of 4 clk -> MISO words 16'h0001 then 16'h0FFF; two frame_done pulses.
- Sample update mid-frame: sample_valid with 12'h123 at SCK edge 6 of a frame carrying 12'h456 -> current frame reads 16'h0456; next frame reads 16'h0123.
- Short frame: CS released after 9 SCK rises -> one frame_err pulse, no frame_done, rx_data keeps its previous value, MISO=0 afterwards.
- Reset handling:
  - Reset asserted at SCK edge 7 -> MISO, busy and miso_oe are 0 on the next clk, and no frame_done or frame_err pulse.
  - CS held low across reset deassertion, then 16 SCK pulses -> no frame starts.
  - A subsequent clean frame returns the correct data.
- Simultaneous events:
  - CS fall detected in the same cycle as sample_valid=1 with 12'h7E1 -> frame carries 16'h07E1.
  - CS rise detected in the same cycle as an SCK rise -> that rise is not counted; a 16-bit frame still gives frame_done.
